// File: rtl/bus_direction_arbiter_if.sv
// Request and transceiver-control signals between the two bus sides and the
// direction arbiter. The master side raises requests; the arbiter is the slave.
interface bus_direction_arbiter_if;
    logic       reqab;
    logic       reqba;
    logic       flowvalveab;
    logic       conflictstatusab;
    logic       prioritystatusab;
    logic       flowvalveba;
    logic       conflictstatusba;
    logic       prioritystatusba;
    logic       busy;
    logic [7:0] conflictcount;

    modport master (
        output reqab,
        output reqba,
        input  flowvalveab,
        input  conflictstatusab,
        input  prioritystatusab,
        input  flowvalveba,
        input  conflictstatusba,
        input  prioritystatusba,
        input  busy,
        input  conflictcount
    );

    modport slave (
        input  reqab,
        input  reqba,
        output flowvalveab,
        output conflictstatusab,
        output prioritystatusab,
        output flowvalveba,
        output conflictstatusba,
        output prioritystatusba,
        output busy,
        output conflictcount
    );
endinterface

// File: rtl/bus_direction_arbiter.sv
// Direction arbiter for a shared bus pair: grants A->B or B->A, never both,
// bounds bursts under contention and inserts dead cycles at each turnaround.
module bus_direction_arbiter #(
    parameter int unsigned MAXBURST = 8,
    parameter int unsigned TURNGAP  = 1
) (
    input  logic                    clock,
    input  logic                    resetn,
    bus_direction_arbiter_if.slave  bus
);

    localparam logic [7:0] MAXB    = 8'(MAXBURST);
    localparam logic [3:0] GAP     = 4'(TURNGAP);
    localparam logic [7:0] CNT_MAX = 8'hFF;

    typedef enum logic [1:0] {IDLE, GRANTAB, GRANTBA, TURN} state_t;
    typedef enum logic {DIR_AB, DIR_BA} dir_t;

    state_t     state_q, state_d;
    dir_t       lastgrant_q, lastgrant_d;
    logic [7:0] burst_q, burst_d, burst_inc;
    logic [3:0] gap_q, gap_d, gap_inc;
    logic [7:0] conflictcount_q, conflictcount_d;
    logic       fvab_q, fvab_d, csab_q, csab_d, psab_q, psab_d;
    logic       fvba_q, fvba_d, csba_q, csba_d, psba_q, psba_d;
    logic       busy_q, busy_d;

    function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic [7:0] lim);
        return (v >= lim) ? lim : v + 8'd1;
    endfunction

    always_comb begin
        state_d         = state_q;
        lastgrant_d     = lastgrant_q;
        burst_d         = burst_q;
        gap_d           = gap_q;
        conflictcount_d = conflictcount_q;
        burst_inc       = sat_inc(burst_q, MAXB);
        gap_inc         = gap_q + 4'd1;

        case (state_q)
            IDLE: begin
                if (bus.reqab && bus.reqba) begin
                    state_d         = (lastgrant_q == DIR_BA) ? GRANTAB : GRANTBA;
                    conflictcount_d = sat_inc(conflictcount_q, CNT_MAX);
                end else if (bus.reqab) begin
                    state_d = GRANTAB;
                end else if (bus.reqba) begin
                    state_d = GRANTBA;
                end
            end
            GRANTAB: begin
                burst_d = burst_inc;
                if (!bus.reqab) begin
                    state_d = bus.reqba ? TURN : IDLE;
                end else if ((burst_inc == MAXB) && bus.reqba) begin
                    state_d         = TURN;
                    conflictcount_d = sat_inc(conflictcount_q, CNT_MAX);
                end
            end
            GRANTBA: begin
                burst_d = burst_inc;
                if (!bus.reqba) begin
                    state_d = bus.reqab ? TURN : IDLE;
                end else if ((burst_inc == MAXB) && bus.reqab) begin
                    state_d         = TURN;
                    conflictcount_d = sat_inc(conflictcount_q, CNT_MAX);
                end
            end
            TURN: begin
                gap_d = gap_inc;
                // Requests are sampled only on the last dead cycle.
                if (gap_inc == GAP) begin
                    if (lastgrant_q == DIR_AB) begin
                        state_d = bus.reqba ? GRANTBA : (bus.reqab ? GRANTAB : IDLE);
                    end else begin
                        state_d = bus.reqab ? GRANTAB : (bus.reqba ? GRANTBA : IDLE);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if ((state_d == TURN) && (state_q != TURN)) begin
            gap_d = 4'd0;
        end
        if ((state_d == GRANTAB) && (state_q != GRANTAB)) begin
            lastgrant_d = DIR_AB;
            burst_d     = 8'd0;
        end
        if ((state_d == GRANTBA) && (state_q != GRANTBA)) begin
            lastgrant_d = DIR_BA;
            burst_d     = 8'd0;
        end

        // Outputs are decoded from the next state so they register with it.
        fvab_d = (state_d == GRANTAB);
        psab_d = (state_d == GRANTAB);
        csab_d = (state_d == GRANTAB) && !bus.reqba;
        fvba_d = (state_d == GRANTBA);
        psba_d = (state_d == GRANTBA);
        csba_d = (state_d == GRANTBA) && !bus.reqab;
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q         <= IDLE;
            lastgrant_q     <= DIR_BA;
            burst_q         <= 8'd0;
            gap_q           <= 4'd0;
            conflictcount_q <= 8'd0;
            fvab_q          <= 1'b0;
            csab_q          <= 1'b0;
            psab_q          <= 1'b0;
            fvba_q          <= 1'b0;
            csba_q          <= 1'b0;
            psba_q          <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            lastgrant_q     <= lastgrant_d;
            burst_q         <= burst_d;
            gap_q           <= gap_d;
            conflictcount_q <= conflictcount_d;
            fvab_q          <= fvab_d;
            csab_q          <= csab_d;
            psab_q          <= psab_d;
            fvba_q          <= fvba_d;
            csba_q          <= csba_d;
            psba_q          <= psba_d;
            busy_q          <= busy_d;
        end
    end

    assign bus.flowvalveab      = fvab_q;
    assign bus.conflictstatusab = csab_q;
    assign bus.prioritystatusab = psab_q;
    assign bus.flowvalveba      = fvba_q;
    assign bus.conflictstatusba = csba_q;
    assign bus.prioritystatusba = psba_q;
    assign bus.busy             = busy_q;
    assign bus.conflictcount    = conflictcount_q;

endmodule

// File: tb/tb_bus_direction_arbiter.sv
// Directed testbench for bus_direction_arbiter (MAXBURST=8, TURNGAP=1).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_bus_direction_arbiter;

    logic clock;
    logic resetn;
    int   checks;
    int   passed;

    bus_direction_arbiter_if bif ();

    bus_direction_arbiter #(
        .MAXBURST(8),
        .TURNGAP (1)
    ) dut (
        .clock (clock),
        .resetn(resetn),
        .bus   (bif.slave)
    );

    // {fvab, csab, psab, fvba, csba, psba, busy}
    logic [6:0] outs;
    assign outs = {bif.flowvalveab, bif.conflictstatusab, bif.prioritystatusab,
                   bif.flowvalveba, bif.conflictstatusba, bif.prioritystatusba, bif.busy};

    localparam logic [6:0] V_IDLE   = 7'b0000000;
    localparam logic [6:0] V_TURN   = 7'b0000001;
    localparam logic [6:0] V_AB_CF  = 7'b1010001;
    localparam logic [6:0] V_AB_NC  = 7'b1110001;
    localparam logic [6:0] V_BA_CF  = 7'b0001011;
    localparam logic [6:0] V_BA_NC  = 7'b0001111;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick;
        @(negedge clock);
    endtask

    task automatic do_reset;
        bif.reqab = 1'b0;
        bif.reqba = 1'b0;
        resetn    = 1'b0;
        tick;
        tick;
        resetn = 1'b1;
    endtask

    task automatic test_reset;
        do_reset;
        checks++;
        if (outs !== V_IDLE) $display("FAIL reset_outs got=%b exp=%b", outs, V_IDLE);
        else passed++;
        checks++;
        if (bif.conflictcount !== 8'd0) $display("FAIL reset_count got=%0d exp=0", bif.conflictcount);
        else passed++;
        tick;
        tick;
        checks++;
        if (outs !== V_IDLE) $display("FAIL idle_outs got=%b exp=%b", outs, V_IDLE);
        else passed++;
    endtask

    task automatic test_single;
        do_reset;
        bif.reqab = 1'b1;
        tick;
        checks++;
        if (outs !== V_AB_NC) $display("FAIL single_grant got=%b exp=%b", outs, V_AB_NC);
        else passed++;
        tick;
        checks++;
        if (outs !== V_AB_NC) $display("FAIL single_hold got=%b exp=%b", outs, V_AB_NC);
        else passed++;
        bif.reqab = 1'b0;
        tick;
        checks++;
        if (outs !== V_IDLE) $display("FAIL single_release got=%b exp=%b", outs, V_IDLE);
        else passed++;
        bif.reqba = 1'b1;
        tick;
        checks++;
        if (outs !== V_BA_NC) $display("FAIL single_ba got=%b exp=%b", outs, V_BA_NC);
        else passed++;
        checks++;
        if (bif.conflictcount !== 8'd0) $display("FAIL single_count got=%0d exp=0", bif.conflictcount);
        else passed++;
        bif.reqba = 1'b0;
        tick;
    endtask

    task automatic test_tie;
        do_reset;
        bif.reqab = 1'b1;
        bif.reqba = 1'b1;
        tick;
        checks++;
        if (outs !== V_AB_CF) $display("FAIL tie_grant got=%b exp=%b", outs, V_AB_CF);
        else passed++;
        checks++;
        if (bif.conflictcount !== 8'd1) $display("FAIL tie_count got=%0d exp=1", bif.conflictcount);
        else passed++;
    endtask

    // Continues from test_tie with both requests held; cycle 1 is the tie grant.
    task automatic test_preempt;
        logic [6:0] exp_v;
        logic [7:0] exp_c;
        for (int c = 2; c <= 28; c++) begin
            tick;
            if ((c - 1) % 9 == 8) exp_v = V_TURN;
            else if (((c - 1) / 9) % 2 == 0) exp_v = V_AB_CF;
            else exp_v = V_BA_CF;
            exp_c = 8'(1 + c / 9);
            checks++;
            if (outs !== exp_v) $display("FAIL preempt_outs cycle=%0d got=%b exp=%b", c, outs, exp_v);
            else passed++;
            checks++;
            if (bif.conflictcount !== exp_c)
                $display("FAIL preempt_count cycle=%0d got=%0d exp=%0d", c, bif.conflictcount, exp_c);
            else passed++;
            checks++;
            if ((bif.flowvalveab & bif.flowvalveba) !== 1'b0)
                $display("FAIL preempt_mutex cycle=%0d got=1 exp=0", c);
            else passed++;
        end
        bif.reqab = 1'b0;
        bif.reqba = 1'b0;
        tick;
        tick;
    endtask

    task automatic test_turn_regrant;
        do_reset;
        bif.reqab = 1'b1;
        bif.reqba = 1'b1;
        for (int c = 1; c <= 9; c++) tick;
        checks++;
        if (outs !== V_TURN) $display("FAIL regrant_turn got=%b exp=%b", outs, V_TURN);
        else passed++;
        bif.reqba = 1'b0;
        tick;
        checks++;
        if (outs !== V_AB_NC) $display("FAIL regrant_ab got=%b exp=%b", outs, V_AB_NC);
        else passed++;
        checks++;
        if (bif.conflictcount !== 8'd2) $display("FAIL regrant_count got=%0d exp=2", bif.conflictcount);
        else passed++;
        bif.reqab = 1'b0;
        tick;
    endtask

    task automatic test_withdraw_turn;
        do_reset;
        bif.reqab = 1'b1;
        bif.reqba = 1'b1;
        tick;
        tick;
        bif.reqab = 1'b0;
        tick;
        checks++;
        if (outs !== V_TURN) $display("FAIL withdraw_turn got=%b exp=%b", outs, V_TURN);
        else passed++;
        bif.reqba = 1'b0;
        tick;
        checks++;
        if (outs !== V_IDLE) $display("FAIL withdraw_idle got=%b exp=%b", outs, V_IDLE);
        else passed++;
        checks++;
        if (bif.conflictcount !== 8'd1) $display("FAIL withdraw_count got=%0d exp=1", bif.conflictcount);
        else passed++;
        bif.reqba = 1'b1;
        tick;
        checks++;
        if (outs !== V_BA_NC) $display("FAIL withdraw_regrant got=%b exp=%b", outs, V_BA_NC);
        else passed++;
        bif.reqba = 1'b0;
        tick;
    endtask

    task automatic test_async_reset;
        do_reset;
        bif.reqab = 1'b1;
        tick;
        checks++;
        if (bif.flowvalveab !== 1'b1) $display("FAIL async_pre got=%b exp=1", bif.flowvalveab);
        else passed++;
        #1;
        resetn = 1'b0;
        #1;
        checks++;
        if (outs !== V_IDLE) $display("FAIL async_drop got=%b exp=%b", outs, V_IDLE);
        else passed++;
        bif.reqab = 1'b0;
        tick;
        resetn = 1'b1;
        tick;
    endtask

    task automatic test_saturation;
        logic [7:0] exp_c;
        do_reset;
        for (int i = 0; i < 300; i++) begin
            bif.reqab = 1'b1;
            bif.reqba = 1'b1;
            tick;
            exp_c = (i + 1 > 255) ? 8'd255 : 8'(i + 1);
            checks++;
            if (bif.flowvalveab !== ((i % 2) == 0))
                $display("FAIL sat_dir tie=%0d got=%b exp=%b", i, bif.flowvalveab, ((i % 2) == 0));
            else passed++;
            checks++;
            if (bif.conflictcount !== exp_c)
                $display("FAIL sat_count tie=%0d got=%0d exp=%0d", i, bif.conflictcount, exp_c);
            else passed++;
            bif.reqab = 1'b0;
            bif.reqba = 1'b0;
            tick;
        end
        checks++;
        if (bif.conflictcount !== 8'd255) $display("FAIL sat_final got=%0d exp=255", bif.conflictcount);
        else passed++;
    endtask

    initial begin
        checks    = 0;
        passed    = 0;
        resetn    = 1'b0;
        bif.reqab = 1'b0;
        bif.reqba = 1'b0;
        test_reset;
        test_single;
        test_tie;
        test_preempt;
        test_turn_regrant;
        test_withdraw_turn;
        test_async_reset;
        test_saturation;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
